// File: rtl/phy_tx_link_pkg.sv
// Shared encodings and constants for the PHY transmit link-training sequencer.
package phy_tx_link_pkg;

  typedef enum logic [1:0] {
    RESET        = 2'b00,
    TRAIN        = 2'b01,
    ACTIVE       = 2'b10,
    RETRAIN_WAIT = 2'b11
  } state_e;

  localparam logic [7:0] COM_WORD_DEF  = 8'hBC;
  localparam logic [7:0] IDLE_WORD_DEF = 8'h7C;
  localparam int unsigned CNT_W        = 4;

endpackage

// File: rtl/phy_tx_consec_cnt.sv
// Saturating consecutive-event counter: hit counts up, miss or clr zeroes it.
// reached flags the hit that completes LIMIT consecutive events (combinational, from the registered count).
module phy_tx_consec_cnt
  import phy_tx_link_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic hit,
  input  logic miss,
  input  logic clr,
  output logic reached
);

  localparam logic [CNT_W-1:0] LIM    = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // reached must not depend on clr: the parent derives clr from the next state
  assign reached = hit && (cnt_q >= LIM_M1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (hit) begin
      if (cnt_q >= LIM_M1) cnt_d = LIM;
      else                 cnt_d = cnt_q + 1'b1;
    end else if (miss) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/phy_tx_link_ctrl.sv
// Link-training/datapath sequencer for the PHY TX path; all outputs registered.
// Optional LINK_STATS_EN adds a saturating count of loss-triggered ACTIVE->TRAIN drops.
module phy_tx_link_ctrl
  import phy_tx_link_pkg::*;
#(
  parameter logic [7:0]  COM_WORD      = COM_WORD_DEF,
  parameter logic [7:0]  IDLE_WORD     = IDLE_WORD_DEF,
  parameter int unsigned LOCK_CNT      = 4,
  parameter int unsigned LOSS_CNT      = 3,
  parameter int unsigned TRAIN_TIMEOUT = 255
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       retrain,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic [7:0] rx_word,
  input  logic       rx_valid,
  output logic [7:0] tx_word,
  output logic       tx_valid,
  output logic       active,
  output logic       link_up,
  output logic       train_timeout,
  output logic [1:0] state_o
`ifdef LINK_STATS_EN
  ,
  output logic [15:0] loss_events
`endif
);

  localparam logic [7:0] TMO_M1 = 8'(TRAIN_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0] tx_word_q, tx_word_d;
  logic       tx_valid_q, tx_valid_d;
  logic       active_q, active_d;
  logic       link_up_q, link_up_d;
  logic       train_timeout_q, train_timeout_d;

  logic in_train, in_active, retrain_train;
  logic lock_hit, lock_miss, lock_reached;
  logic loss_hit, loss_miss, loss_reached;
  logic tmo_hit, cnt_clr;

  assign in_train      = (state_q == TRAIN);
  assign in_active     = (state_q == ACTIVE);
  assign retrain_train = in_train && retrain;
  assign lock_hit      = in_train && rx_valid && (rx_word == COM_WORD);
  assign lock_miss     = in_train && !lock_hit;
  assign loss_hit      = in_active && !rx_valid;
  assign loss_miss     = in_active && rx_valid;
  assign tmo_hit       = in_train && !retrain && (tmo_cnt_q == TMO_M1);
  assign cnt_clr       = (state_d != state_q) || retrain_train;

  phy_tx_consec_cnt #(.LIMIT(LOCK_CNT)) u_lock_cnt (
    .clk     (clk_4f),
    .reset   (reset),
    .hit     (lock_hit),
    .miss    (lock_miss),
    .clr     (cnt_clr),
    .reached (lock_reached)
  );

  phy_tx_consec_cnt #(.LIMIT(LOSS_CNT)) u_loss_cnt (
    .clk     (clk_4f),
    .reset   (reset),
    .hit     (loss_hit),
    .miss    (loss_miss),
    .clr     (cnt_clr),
    .reached (loss_reached)
  );

  // Next state: retrain outranks loss, loss outranks lock
  always_comb begin
    state_d         = state_q;
    train_timeout_d = train_timeout_q;
    tmo_cnt_d       = tmo_cnt_q;
    unique case (state_q)
      RESET:        state_d = TRAIN;
      TRAIN:        if (!retrain && lock_reached) state_d = ACTIVE;
      ACTIVE: begin
        if (retrain)           state_d = RETRAIN_WAIT;
        else if (loss_reached) state_d = TRAIN;
      end
      RETRAIN_WAIT: if (!data_valid) state_d = TRAIN;
      default:      state_d = RESET;
    endcase

    if (tmo_hit) train_timeout_d = 1'b1;
    if (cnt_clr || tmo_hit) tmo_cnt_d = '0;
    else if (in_train)      tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  // Outputs are decoded from the next state so they line up with state_q
  always_comb begin
    tx_word_d  = IDLE_WORD;
    tx_valid_d = 1'b0;
    active_d   = 1'b0;
    link_up_d  = 1'b0;
    unique case (state_d)
      TRAIN: begin
        tx_word_d  = COM_WORD;
        tx_valid_d = 1'b1;
      end
      ACTIVE: begin
        tx_word_d  = data_valid ? data_in : IDLE_WORD;
        tx_valid_d = 1'b1;
        active_d   = 1'b1;
        link_up_d  = 1'b1;
      end
      RETRAIN_WAIT: tx_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q         <= RESET;
      tmo_cnt_q       <= '0;
      tx_word_q       <= IDLE_WORD;
      tx_valid_q      <= 1'b0;
      active_q        <= 1'b0;
      link_up_q       <= 1'b0;
      train_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tmo_cnt_q       <= tmo_cnt_d;
      tx_word_q       <= tx_word_d;
      tx_valid_q      <= tx_valid_d;
      active_q        <= active_d;
      link_up_q       <= link_up_d;
      train_timeout_q <= train_timeout_d;
    end
  end

  assign tx_word       = tx_word_q;
  assign tx_valid      = tx_valid_q;
  assign active        = active_q;
  assign link_up       = link_up_q;
  assign train_timeout = train_timeout_q;
  assign state_o       = state_q;

`ifdef LINK_STATS_EN
  logic [15:0] loss_events_q, loss_events_d;
  logic        loss_drop;

  assign loss_drop = in_active && !retrain && loss_reached;

  always_comb begin
    loss_events_d = loss_events_q;
    if (loss_drop && (loss_events_q != 16'hFFFF)) loss_events_d = loss_events_q + 16'd1;
  end

  always_ff @(posedge clk_4f) begin
    if (reset) loss_events_q <= '0;
    else       loss_events_q <= loss_events_d;
  end

  assign loss_events = loss_events_q;
`endif

endmodule

// File: tb/tb_phy_tx_link_ctrl.sv
// Directed self-checking bench for phy_tx_link_ctrl (default parameters).
module tb_phy_tx_link_ctrl;

  logic       clk_4f = 1'b0;
  logic       reset, retrain, data_valid, rx_valid;
  logic [7:0] data_in, rx_word;
  logic [7:0] tx_word;
  logic       tx_valid, active, link_up, train_timeout;
  logic [1:0] state_o;
`ifdef LINK_STATS_EN
  logic [15:0] loss_events;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_RESET = 2'b00, S_TRAIN = 2'b01, S_ACTIVE = 2'b10, S_RWAIT = 2'b11;

  always #5 clk_4f = ~clk_4f;

  phy_tx_link_ctrl dut (
    .clk_4f        (clk_4f),
    .reset         (reset),
    .retrain       (retrain),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .rx_word       (rx_word),
    .rx_valid      (rx_valid),
    .tx_word       (tx_word),
    .tx_valid      (tx_valid),
    .active        (active),
    .link_up       (link_up),
    .train_timeout (train_timeout),
    .state_o       (state_o)
`ifdef LINK_STATS_EN
    ,
    .loss_events   (loss_events)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_4f);
      #1;
    end
  endtask

  task automatic rx(input logic v, input logic [7:0] w);
    rx_valid = v;
    rx_word  = w;
  endtask

  initial begin
    reset = 1'b1; retrain = 1'b0; data_in = 8'h00; data_valid = 1'b0;
    rx_valid = 1'b0; rx_word = 8'h00;

    // 1. reset and entry into TRAIN
    tick(3);
    chk("rst_state", state_o, S_RESET);
    chk("rst_txw", tx_word, 8'h7C);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_act", active, 1'b0);
    chk("rst_lnk", link_up, 1'b0);
    chk("rst_tmo", train_timeout, 1'b0);
    reset = 1'b0;
    tick(1);
    chk("tr_state", state_o, S_TRAIN);
    chk("tr_txw", tx_word, 8'hBC);
    chk("tr_txv", tx_valid, 1'b1);
    chk("tr_act", active, 1'b0);
    tick(2);
    chk("tr_hold", state_o, S_TRAIN);

    // 2. lock on the 4th COM, then datapath
    rx(1'b1, 8'hBC);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("lock_pre", state_o, S_TRAIN);
    end
    tick(1);
    chk("lock_state", state_o, S_ACTIVE);
    chk("lock_act", active, 1'b1);
    chk("lock_lnk", link_up, 1'b1);
    chk("lock_idle", tx_word, 8'h7C);
    data_in = 8'h5A; data_valid = 1'b1;
    tick(1);
    chk("dat_txw", tx_word, 8'h5A);
    chk("dat_txv", tx_valid, 1'b1);
    data_valid = 1'b0;
    tick(1);
    chk("dat_idle", tx_word, 8'h7C);

    // 4. loss after 3 invalid cycles
    rx(1'b0, 8'h00);
    tick(2);
    chk("loss_pre", state_o, S_ACTIVE);
    tick(1);
    chk("loss_state", state_o, S_TRAIN);
    chk("loss_act", active, 1'b0);
    chk("loss_txw", tx_word, 8'hBC);
`ifdef LINK_STATS_EN
    chk("loss_evt", loss_events, 16'd1);
`endif

    // 3. broken lock: 3xBC, 00, 4xBC -> lock on 8th rx cycle
    rx(1'b1, 8'hBC);
    tick(3);
    chk("brk_a", state_o, S_TRAIN);
    rx(1'b1, 8'h00);
    tick(1);
    chk("brk_b", state_o, S_TRAIN);
    rx(1'b1, 8'hBC);
    tick(3);
    chk("brk_c", state_o, S_TRAIN);
    tick(1);
    chk("brk_lock", state_o, S_ACTIVE);

    // two low then one high keeps ACTIVE, and the loss count restarts
    rx(1'b0, 8'h00);
    tick(2);
    rx(1'b1, 8'hBC);
    tick(1);
    chk("nl_a", state_o, S_ACTIVE);
    rx(1'b0, 8'h00);
    tick(2);
    chk("nl_b", state_o, S_ACTIVE);
    rx(1'b1, 8'hBC);

    // 6. retrain waits for data_valid to drop
    data_in = 8'h33; data_valid = 1'b1; retrain = 1'b1;
    tick(1);
    retrain = 1'b0;
    chk("rw_state", state_o, S_RWAIT);
    chk("rw_txw", tx_word, 8'h7C);
    chk("rw_txv", tx_valid, 1'b1);
    chk("rw_act", active, 1'b0);
    chk("rw_lnk", link_up, 1'b0);
    tick(2);
    chk("rw_hold", state_o, S_RWAIT);
    data_valid = 1'b0;
    tick(1);
    chk("rw_exit", state_o, S_TRAIN);
    chk("rw_txbc", tx_word, 8'hBC);
`ifdef LINK_STATS_EN
    chk("rw_evt", loss_events, 16'd1);
`endif

    // 5. timeout on the 255th TRAIN cycle, sticky
    rx(1'b0, 8'h00);
    tick(254);
    chk("tmo_pre", train_timeout, 1'b0);
    tick(1);
    chk("tmo_set", train_timeout, 1'b1);
    chk("tmo_state", state_o, S_TRAIN);
    tick(10);
    chk("tmo_stick", train_timeout, 1'b1);

    // retrain in TRAIN restarts the lock count
    rx(1'b1, 8'hBC);
    tick(3);
    retrain = 1'b1;
    tick(1);
    retrain = 1'b0;
    chk("rt_tr", state_o, S_TRAIN);
    tick(3);
    chk("rt_pre", state_o, S_TRAIN);
    tick(1);
    chk("rt_lock", state_o, S_ACTIVE);
    chk("tmo_act", train_timeout, 1'b1);

    // reset from RETRAIN_WAIT
    data_valid = 1'b1; retrain = 1'b1;
    tick(1);
    retrain = 1'b0;
    chk("rr_wait", state_o, S_RWAIT);
    reset = 1'b1;
    tick(1);
    chk("rr_state", state_o, S_RESET);
    chk("rr_txw", tx_word, 8'h7C);
    chk("rr_txv", tx_valid, 1'b0);
    chk("rr_act", active, 1'b0);
    chk("rr_lnk", link_up, 1'b0);
    chk("rr_tmo", train_timeout, 1'b0);
`ifdef LINK_STATS_EN
    chk("rr_evt", loss_events, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
